// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and default sizes.
package mult_arb_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned IDW_DEF   = $clog2(NREQ_DEF);
    localparam int unsigned CNTW_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/grant and response bus between the requesters/consumer and the arbiter.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned IDW   = IDW_DEF
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_multiplier;
    logic [NREQ*WIDTH-1:0] op_multiplicand;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  rsp_ready;

    modport master (
        output req, op_multiplier, op_multiplicand, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req, op_multiplier, op_multiplicand, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_product
    );

endinterface

// File: rtl/multiplier_booths.sv
// Sequential radix-2 Booth multiplier for two's-complement operands, one step per clock.
// The counter free-runs after load: done is sticky and the product is reworked on counter wrap.
module multiplier_booths #(
    parameter int unsigned width = 8,
    parameter int unsigned no    = 4
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               load,
    input  logic [width-1:0]   multiplier,
    input  logic [width-1:0]   multiplicand,
    output logic [2*width-1:0] product,
    output logic               done
);

    // One guard bit on the accumulator keeps subtraction of the most negative multiplicand exact.
    logic [width:0]   acc;
    logic [width:0]   mcand;
    logic [width:0]   acc_sum;
    logic [width-1:0] q;
    logic             q_1;
    logic [no-1:0]    count;

    always_comb begin
        acc_sum = acc;
        unique case ({q[0], q_1})
            2'b01:   acc_sum = acc + mcand;
            2'b10:   acc_sum = acc - mcand;
            default: acc_sum = acc;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            acc   <= '0;
            mcand <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            mcand <= {multiplicand[width-1], multiplicand};
            q     <= multiplier;
            q_1   <= 1'b0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= count + no'(1);
            if (count < no'(width)) begin
                acc <= {acc_sum[width], acc_sum[width:1]};
                q   <= {acc_sum[0], q[width-1:1]};
                q_1 <= q[0];
            end
            if (count == no'(width)) begin
                done <= 1'b1;
            end
        end
    end

    assign product = {acc[width-1:0], q};

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among NREQ requesters,
// with a valid/ready response carrying the owner ID and product.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned IDW   = IDW_DEF,
    parameter int unsigned CNTW  = CNTW_DEF
) (
    input  logic           clock,
    input  logic           clear_n,
    mult_arbiter_if.slave  bus,
    output logic           busy
);

    state_t             state;
    logic [IDW-1:0]     last_id;
    logic [WIDTH-1:0]   cap_multiplier;
    logic [WIDTH-1:0]   cap_multiplicand;

    logic               pick_valid;
    logic [IDW-1:0]     pick_id;
    logic [IDW-1:0]     rr_idx;
    logic [WIDTH-1:0]   pick_multiplier;
    logic [WIDTH-1:0]   pick_multiplicand;

    logic               core_load;
    logic               core_done;
    logic [2*WIDTH-1:0] core_product;

    // Round-robin search from last_id+1; walking offsets downward lets the nearest requester win.
    always_comb begin
        pick_valid        = 1'b0;
        pick_id           = '0;
        rr_idx            = '0;
        pick_multiplier   = '0;
        pick_multiplicand = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            rr_idx = IDW'((32'(last_id) + 32'(k)) % NREQ);
            if (bus.req[rr_idx]) begin
                pick_valid = 1'b1;
                pick_id    = rr_idx;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_id == IDW'(i)) begin
                pick_multiplier   = bus.op_multiplier[i*WIDTH +: WIDTH];
                pick_multiplicand = bus.op_multiplicand[i*WIDTH +: WIDTH];
            end
        end
    end

    assign core_load = (state == LOAD);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state            <= IDLE;
            last_id          <= IDW'(NREQ - 1);
            cap_multiplier   <= '0;
            cap_multiplicand <= '0;
            bus.gnt          <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= '0;
            bus.rsp_product  <= '0;
            busy             <= 1'b0;
        end else begin
            bus.gnt <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cap_multiplier   <= pick_multiplier;
                        cap_multiplicand <= pick_multiplicand;
                        last_id          <= pick_id;
                        bus.rsp_id       <= pick_id;
                        bus.gnt          <= NREQ'(1) << pick_id;
                        busy             <= 1'b1;
                        state            <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                // Core done is stale outside RUN; only the first done after LOAD is trusted.
                RUN: begin
                    if (core_done) begin
                        bus.rsp_product <= core_product;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    multiplier_booths #(
        .width (WIDTH),
        .no    (CNTW)
    ) u_core (
        .clock        (clock),
        .clear_n      (clear_n),
        .load         (core_load),
        .multiplier   (cap_multiplier),
        .multiplicand (cap_multiplicand),
        .product      (core_product),
        .done         (core_done)
    );

endmodule
